ibex_pmp_check_arbiter: RTL and testbench
=========================================

# ibex_pmp_check_arbiter

Shares a single PMP permission-check channel between several requesters, e.g. instruction fetch, LSU and debug module. Each requester uses a valid/ready handshake to present an address, access type and privilege mode. A round-robin arbiter picks one request per cycle and holds it in a check register that drives the shared PMP channel. The combinational PMP verdict is captured into a response register that is returned with the requester ID under a valid/ready handshake.

## Interface
Parameters:
- NumReq, 3, number of requesters (2..8)
- IdW, $clog2(NumReq), width of the requester ID

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester accept; at most one bit high per cycle
- req_addr_i  in  NumReq*34  per-requester 34-bit physical address; requester k occupies bits [34k+33:34k]
- req_type_i  in  NumReq*2  per-requester access type: 00 exec, 01 write, 10 read
- req_priv_i  in  NumReq*2  per-requester privilege: 11 M, 00 U
- pmp_req_addr_o  out  34  address of the held request, driven to the PMP channel
- pmp_req_type_o  out  2  type of the held request
- pmp_priv_mode_o  out  2  privilege of the held request
- pmp_req_err_i  in  1  combinational PMP verdict for the current pmp_* outputs; 1 = fault
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_id_o  out  IdW  index of the requester owning the response
- rsp_err_o  out  1  1 = access fault
- busy_o  out  1  1 while either pipeline stage holds a request
- fault_cnt_o  out  8  saturating count of delivered fault responses

## Operation
Pipeline state:
- Stage C (check): c_valid, c_id, c_addr, c_type, c_priv.
- Stage R (response): r_valid, r_id, r_err.
- Arbitration pointer: ptr, IdW bits.

Arbitration:
- Candidate = first k with req_valid_i[k] = 1, searching ptr, ptr+1, … with wrap at NumReq.
- Mapped to NumReq-1 → 0, never to an out-of-range index.

Handshakes:
- r_free = !r_valid | rsp_ready_i.
- c_move = c_valid & r_free.
- c_free = !c_valid | c_move.
- req_ready_o[k] = c_free & (k == candidate) & req_valid_i[k].
- req_ready_o does not depend on req_valid_i of other requesters beyond the arbitration search.

Updates on each edge:
- Accept (any req_ready_o bit high): load stage C from the winner and set c_valid. Set ptr = winner+1, wrapping NumReq-1 → 0.
- c_move: load r_id = c_id and r_err = pmp_req_err_i, then set r_valid.
- c_move with no accept: clear c_valid.
- rsp_valid_o & rsp_ready_i with no c_move: clear r_valid.
- Response handshake with rsp_err_o = 1: increment fault_cnt_o, saturating at 255.

Output rules:
- pmp_* outputs always reflect the stage C registers; they hold their last values when c_valid = 0.
- rsp_valid_o = r_valid, rsp_id_o = r_id, rsp_err_o = r_err.
- busy_o = c_valid | r_valid.

## Timing
- Reset values: c_valid = 0, r_valid = 0, ptr = 0, stage C data = 0, r_id = 0, r_err = 0, fault_cnt_o = 0.
- Consequently after reset: all pmp_* = 0, req_ready_o = 0 until a valid request arrives, rsp_valid_o = 0, busy_o = 0.
- Latency: a request accepted on edge t produces rsp_valid_o high in the cycle after edge t+1, i.e. 2 cycles.
- Throughput: 1 request per cycle while rsp_ready_i stays high.
- Backpressure: with rsp_ready_i low, stage R holds and stage C holds. The PMP verdict is re-evaluated every cycle and captured on the moving edge. All req_ready_o drop once both stages are full.
- Simultaneous consume, move and accept in one cycle: all three occur; no bubble.
- Mid-operation reset: rst_i high on any edge discards both stages without producing a response and returns to the reset state. The requester in flight must re-issue.
- Rotation: a requester holding req_valid_i high is granted within NumReq accepts.

## Test plan
- Single request, NumReq = 3: req 1 valid with addr 0x0_0000_1000, type 10, priv 00, pmp_req_err_i = 0 → req_ready_o = 3'b010 in cycle 0; pmp_req_addr_o = 0x0_0000_1000 in cycle 1; rsp_valid_o = 1, rsp_id_o = 1, rsp_err_o = 0 in cycle 2.
- All three requesters continuously valid, rsp_ready_i = 1 → grant order 0, 1, 2, 0, 1, 2; 6 responses on consecutive cycles with IDs in the same order.
- Backpressure: two requests accepted, then rsp_ready_i = 0 for 4 cycles → rsp_valid_o stays high with the first ID, busy_o = 1, req_ready_o = 0. On release, both responses follow on consecutive cycles.
- Fault counting: pmp_req_err_i forced to 1 for 300 responses → each rsp_err_o = 1; fault_cnt_o saturates at 255 and stays there.
- Reset while both stages are full → next cycle rsp_valid_o = 0, busy_o = 0, fault_cnt_o = 0, ptr = 0. The first grant after reset goes to requester 0 when all are valid.
- Wrap-around: ptr = 2, only req 0 valid → grant 0, then ptr = 1.

Source files
------------

// File: rtl/ibex_pmp_check_arbiter.sv
// rtl/ibex_pmp_check_arbiter.sv - round-robin arbiter sharing one PMP check channel
// Two-stage pipeline: stage C drives the PMP channel, stage R returns the verdict.
module ibex_pmp_check_arbiter #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*34-1:0]   req_addr_i,
  input  logic [NumReq*2-1:0]    req_type_i,
  input  logic [NumReq*2-1:0]    req_priv_i,
  output logic [33:0]            pmp_req_addr_o,
  output logic [1:0]             pmp_req_type_o,
  output logic [1:0]             pmp_priv_mode_o,
  input  logic                   pmp_req_err_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IdW-1:0]         rsp_id_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [7:0]             fault_cnt_o
);

  localparam logic [IdW:0] NumReqW = (IdW+1)'(NumReq);

  logic             c_valid_q, r_valid_q, r_err_q;
  logic [IdW-1:0]   c_id_q, r_id_q, ptr_q, ptr_d;
  logic [33:0]      c_addr_q;
  logic [1:0]       c_type_q, c_priv_q;
  logic [7:0]       fault_cnt_q, fault_cnt_d;

  logic [NumReq-1:0] valid_rot;
  logic             cand_valid, r_free, c_move, c_free, accept, rsp_fire;
  logic [IdW-1:0]   cand_off, cand_id;
  logic [33:0]      win_addr;
  logic [1:0]       win_type, win_priv;

  // Modular add keeps every index inside 0..NumReq-1 for non-power-of-two NumReq.
  function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] a, input logic [IdW-1:0] b);
    logic [IdW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NumReqW) s = s - NumReqW;
    return s[IdW-1:0];
  endfunction

  always_comb begin
    valid_rot = '0;
    for (int i = 0; i < NumReq; i++) begin
      valid_rot[i] = req_valid_i[wrap_add(ptr_q, IdW'(i))];
    end
  end

  // Lowest rotated offset wins, so the search starts at ptr.
  always_comb begin
    cand_valid = 1'b0;
    cand_off   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        cand_valid = 1'b1;
        cand_off   = IdW'(i);
      end
    end
  end

  assign cand_id  = wrap_add(ptr_q, cand_off);
  assign r_free   = !r_valid_q || rsp_ready_i;
  assign c_move   = c_valid_q && r_free;
  assign c_free   = !c_valid_q || c_move;
  assign rsp_fire = r_valid_q && rsp_ready_i;

  always_comb begin
    req_ready_o = '0;
    win_addr    = '0;
    win_type    = '0;
    win_priv    = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (cand_id == IdW'(k)) begin
        win_addr = req_addr_i[34*k +: 34];
        win_type = req_type_i[2*k +: 2];
        win_priv = req_priv_i[2*k +: 2];
      end
      req_ready_o[k] = c_free && cand_valid && (cand_id == IdW'(k)) && req_valid_i[k];
    end
  end

  assign accept      = |req_ready_o;
  assign ptr_d       = wrap_add(cand_id, IdW'(1));
  assign fault_cnt_d = (rsp_fire && r_err_q && fault_cnt_q != 8'hFF) ? fault_cnt_q + 8'd1
                                                                     : fault_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_valid_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      ptr_q       <= '0;
      c_id_q      <= '0;
      c_addr_q    <= '0;
      c_type_q    <= '0;
      c_priv_q    <= '0;
      r_id_q      <= '0;
      r_err_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      if (accept) begin
        c_id_q   <= cand_id;
        c_addr_q <= win_addr;
        c_type_q <= win_type;
        c_priv_q <= win_priv;
        ptr_q    <= ptr_d;
      end
      if (c_move) begin
        r_id_q  <= c_id_q;
        r_err_q <= pmp_req_err_i;
      end
      if (accept)      c_valid_q <= 1'b1;
      else if (c_move) c_valid_q <= 1'b0;
      if (c_move)        r_valid_q <= 1'b1;
      else if (rsp_fire) r_valid_q <= 1'b0;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign pmp_req_addr_o  = c_addr_q;
  assign pmp_req_type_o  = c_type_q;
  assign pmp_priv_mode_o = c_priv_q;
  assign rsp_valid_o     = r_valid_q;
  assign rsp_id_o        = r_id_q;
  assign rsp_err_o       = r_err_q;
  assign busy_o          = c_valid_q || r_valid_q;
  assign fault_cnt_o     = fault_cnt_q;

endmodule

// File: tb/tb_ibex_pmp_check_arbiter.sv
// tb/tb_ibex_pmp_check_arbiter.sv - randomized and directed bench with in-flight queue model
module tb_ibex_pmp_check_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*34-1:0] req_addr;
  logic [N*2-1:0] req_type, req_priv;
  logic [33:0]   pmp_addr;
  logic [1:0]    pmp_type, pmp_priv;
  logic          pmp_err, rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]    rsp_id;
  logic [7:0]    fault_cnt;

  ibex_pmp_check_arbiter #(.NumReq(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_type_i(req_type), .req_priv_i(req_priv),
    .pmp_req_addr_o(pmp_addr), .pmp_req_type_o(pmp_type), .pmp_priv_mode_o(pmp_priv),
    .pmp_req_err_i(pmp_err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err),
    .busy_o(busy), .fault_cnt_o(fault_cnt)
  );

  always #5 clk = ~clk;

  // Model: ordered list of in-flight requests; the oldest one with a captured verdict is the response.
  typedef struct { int id; bit done; bit err; } item_t;
  item_t q[$];
  int m_ptr, m_fault, cand;
  logic [33:0] m_paddr;
  logic [1:0] m_ptype, m_ppriv;
  bit rv, cv, cons, mv, cf, mdl_on;
  logic [N-1:0] exp_ready;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void predict();
    rv = q.size() > 0 && q[0].done;
    cv = q.size() > 0 && !q[q.size()-1].done;
    cons = rv && rsp_ready;
    mv = cv && (!rv || rsp_ready);
    cf = !cv || mv;
    cand = -1;
    for (int d = 0; d < N; d++)
      if (cand < 0 && req_valid[(m_ptr + d) % N]) cand = (m_ptr + d) % N;
    exp_ready = (cf && cand >= 0) ? N'(1 << cand) : '0;
  endfunction

  task automatic model_compare();
    predict();
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(rv));
    if (rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
    end
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("pmp_addr", 64'(pmp_addr), 64'(m_paddr));
    chk("pmp_type", 64'(pmp_type), 64'(m_ptype));
    chk("pmp_priv", 64'(pmp_priv), 64'(m_ppriv));
    chk("fault_cnt", 64'(fault_cnt), 64'(m_fault));
  endtask

  task automatic model_step();
    item_t it;
    predict();
    if (rst) begin
      q.delete();
      m_ptr = 0; m_fault = 0; m_paddr = '0; m_ptype = '0; m_ppriv = '0;
    end else begin
      if (cons) begin
        if (q[0].err && m_fault < 255) m_fault++;
        void'(q.pop_front());
      end
      if (mv) begin
        q[q.size()-1].done = 1'b1;
        q[q.size()-1].err  = pmp_err;
      end
      if (exp_ready != '0) begin
        it.id = cand; it.done = 1'b0; it.err = 1'b0;
        q.push_back(it);
        m_ptr   = (cand + 1) % N;
        m_paddr = req_addr[34*cand +: 34];
        m_ptype = req_type[2*cand +: 2];
        m_ppriv = req_priv[2*cand +: 2];
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (mdl_on) model_compare();
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mdl_on = 1'b0;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_type = '0; req_priv = '0;
    pmp_err = 1'b0; rsp_ready = 1'b1;
    step();
    mdl_on = 1'b1;
    step();
    rst = 1'b0;

    settle();
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_pmp_addr", 64'(pmp_addr), 0);
    chk("rst_fault", 64'(fault_cnt), 0);
    step();

    req_valid = 3'b010; req_addr[34 +: 34] = 34'h0_0000_1000; req_type[3:2] = 2'b10; req_priv[3:2] = 2'b00;
    settle(); chk("single_ready", 64'(req_ready), 64'b010); step();
    req_valid = '0;
    settle(); chk("single_pmp_addr", 64'(pmp_addr), 64'h1000); step();
    settle();
    chk("single_rsp_valid", 64'(rsp_valid), 1);
    chk("single_rsp_id", 64'(rsp_id), 1);
    chk("single_rsp_err", 64'(rsp_err), 0);
    step();
    rst = 1'b1; settle(); step(); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 6) ? 3'b111 : 3'b000;
      settle();
      if (i < 6) chk("rot_grant", 64'(req_ready), 64'(1 << (i % 3)));
      if (i >= 2) begin
        chk("rot_rsp_valid", 64'(rsp_valid), 1);
        chk("rot_rsp_id", 64'(rsp_id), 64'((i - 2) % 3));
      end
      step();
    end

    req_valid = 3'b111; rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin settle(); step(); end
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_rsp_valid", 64'(rsp_valid), 1);
      chk("bp_rsp_id", 64'(rsp_id), 0);
      chk("bp_busy", 64'(busy), 1);
      chk("bp_ready", 64'(req_ready), 0);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    settle(); chk("bp_rel0_valid", 64'(rsp_valid), 1); chk("bp_rel0_id", 64'(rsp_id), 0); step();
    settle(); chk("bp_rel1_valid", 64'(rsp_valid), 1); chk("bp_rel1_id", 64'(rsp_id), 1); step();
    settle(); chk("bp_drained", 64'(busy), 0); step();

    req_valid = 3'b001;
    settle(); chk("wrap_grant0", 64'(req_ready), 64'b001); step();
    req_valid = 3'b111;
    settle(); chk("wrap_ptr1", 64'(req_ready), 64'b010); step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin settle(); step(); end

    req_valid = 3'b001; pmp_err = 1'b1;
    for (int i = 0; i < 305; i++) begin
      settle();
      if (rsp_valid) chk("fault_rsp_err", 64'(rsp_err), 1);
      step();
    end
    req_valid = '0;
    settle(); chk("fault_sat", 64'(fault_cnt), 255); step();
    settle(); step();
    settle(); chk("fault_hold", 64'(fault_cnt), 255); step();
    pmp_err = 1'b0;

    req_valid = 3'b111; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin settle(); step(); end
    settle(); chk("full_busy", 64'(busy), 1); chk("full_ready", 64'(req_ready), 0);
    rst = 1'b1; step(); rst = 1'b0;
    settle();
    chk("rstfull_rsp_valid", 64'(rsp_valid), 0);
    chk("rstfull_busy", 64'(busy), 0);
    chk("rstfull_fault", 64'(fault_cnt), 0);
    chk("rstfull_grant0", 64'(req_ready), 64'b001);
    step();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      req_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        req_addr[34*k +: 34] = {2'($urandom), 32'($urandom)};
        req_type[2*k +: 2]   = 2'($urandom_range(2));
        req_priv[2*k +: 2]   = $urandom_range(1) ? 2'b11 : 2'b00;
      end
      pmp_err   = $urandom_range(3) == 0;
      rsp_ready = $urandom_range(9) < 7;
      settle();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
